// File: rtl/iob_sched.sv
`default_nettype none
// ============================================================================
// Module   : iob_sched
// Summary  : FSB-to-IOB request scheduler. Holds one staged posted write plus
//            in-order non-posted accesses and drives IOREQ/IOACT/IODONE.
//            Optional bus-error termination: define IOB_SCHED_BERR_EN.
// Revision : 1.0  initial release
// ============================================================================
module iob_sched (
    input  logic CLK,
    input  logic nRES,
    input  logic PWReq,
    input  logic PWL,
    input  logic PWU,
    output logic PWReady,
    output logic PWEmpty,
    input  logic NPReq,
    input  logic NPRW,
    input  logic NPL,
    input  logic NPU,
    output logic NPDone,
    output logic NPErr,
    output logic PWErr,
    input  logic BERRin,
    output logic ALE1,
    output logic ALE0,
    output logic IOREQ,
    output logic IORW,
    output logic IOL,
    output logic IOU,
    input  logic IOACT,
    input  logic IODONE
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_REQ  = 2'd2;
    localparam logic [1:0] c_ACT  = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_stateNxt;
    logic       r_actMeta;
    logic       r_actSync;
    logic       r_doneMeta;
    logic       r_doneSync;
    logic       r_stgValid;
    logic       w_stgValidNxt;
    logic       r_shL;
    logic       r_shU;
    logic       r_kindPw;
    logic       w_kindPwNxt;
    logic       r_pwReady;
    logic       r_pwEmpty;
    logic       r_npDone;
    logic       r_npErr;
    logic       r_pwErr;
    logic       r_ale1;
    logic       r_ale0;
    logic       r_ioReq;
    logic       r_ioRw;
    logic       r_ioL;
    logic       r_ioU;
    logic       w_enq;
    logic       w_idleClear;
    logic       w_startPw;
    logic       w_startNp;
    logic       w_berr;
    logic       w_finish;

`ifdef IOB_SCHED_BERR_EN
    assign w_berr = BERRin;
`else
    logic w_unusedBerr;
    assign w_unusedBerr = BERRin;
    assign w_berr       = 1'b0;
`endif

    assign w_enq       = PWReq & r_pwReady;
    // Stale IOB status from the previous transaction must clear before a new LOAD.
    assign w_idleClear = (r_state == c_IDLE) & ~r_actSync & ~r_doneSync;
    assign w_startPw   = w_idleClear & r_stgValid;
    // A staged write always goes first; r_npDone blocks re-issue while the
    // requester is still seeing its completion pulse.
    assign w_startNp   = w_idleClear & ~r_stgValid & NPReq & ~w_enq & ~r_npDone;
    assign w_finish    = (r_state == c_ACT) & (r_doneSync | w_berr);

    assign w_stgValidNxt = w_enq | (r_stgValid & ~((r_state == c_LOAD) & r_kindPw));
    assign w_kindPwNxt   = (w_startPw | w_startNp) ? w_startPw : r_kindPw;

    always_comb begin
        w_stateNxt = r_state;
        case (r_state)
            c_IDLE:  if (w_startPw || w_startNp) w_stateNxt = c_LOAD;
            c_LOAD:  w_stateNxt = c_REQ;
            c_REQ:   if (r_actSync) w_stateNxt = c_ACT;
            c_ACT:   if (w_finish) w_stateNxt = c_IDLE;
            default: w_stateNxt = c_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            r_state    <= c_IDLE;
            r_actMeta  <= 1'b0;
            r_actSync  <= 1'b0;
            r_doneMeta <= 1'b0;
            r_doneSync <= 1'b0;
            r_stgValid <= 1'b0;
            r_shL      <= 1'b0;
            r_shU      <= 1'b0;
            r_kindPw   <= 1'b0;
            r_pwReady  <= 1'b1;
            r_pwEmpty  <= 1'b1;
            r_npDone   <= 1'b0;
            r_npErr    <= 1'b0;
            r_pwErr    <= 1'b0;
            r_ale1     <= 1'b0;
            r_ale0     <= 1'b0;
            r_ioReq    <= 1'b0;
            r_ioRw     <= 1'b0;
            r_ioL      <= 1'b0;
            r_ioU      <= 1'b0;
        end else begin
            r_actMeta  <= IOACT;
            r_actSync  <= r_actMeta;
            r_doneMeta <= IODONE;
            r_doneSync <= r_doneMeta;
            r_state    <= w_stateNxt;
            r_stgValid <= w_stgValidNxt;
            r_kindPw   <= w_kindPwNxt;
            if (w_enq) begin
                r_shL <= PWL;
                r_shU <= PWU;
            end
            // Attributes are captured as LOAD is entered and held until the next LOAD.
            if (w_startPw) begin
                r_ioRw <= 1'b0;
                r_ioL  <= r_shL;
                r_ioU  <= r_shU;
            end else if (w_startNp) begin
                r_ioRw <= NPRW;
                r_ioL  <= NPL;
                r_ioU  <= NPU;
            end
            r_pwReady <= ~w_stgValidNxt;
            r_pwEmpty <= ~w_stgValidNxt & ~((w_stateNxt != c_IDLE) & w_kindPwNxt);
            r_ale1    <= w_enq | w_startNp;
            r_ale0    <= w_startPw | w_startNp;
            r_ioReq   <= (w_stateNxt == c_REQ);
            r_npDone  <= w_finish & ~r_kindPw;
            r_npErr   <= w_finish & ~r_kindPw & w_berr;
            r_pwErr   <= r_pwErr | (w_finish & r_kindPw & w_berr);
        end
    end

    assign PWReady = r_pwReady;
    assign PWEmpty = r_pwEmpty;
    assign NPDone  = r_npDone;
    assign NPErr   = r_npErr;
    assign PWErr   = r_pwErr;
    assign ALE1    = r_ale1;
    assign ALE0    = r_ale0;
    assign IOREQ   = r_ioReq;
    assign IORW    = r_ioRw;
    assign IOL     = r_ioL;
    assign IOU     = r_ioU;

endmodule
`default_nettype wire

// File: tb/tb_iob_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_sched
// Summary  : Self-checking bench for iob_sched; the bench plays the FSB side
//            and the IOB master, with an in-order queue of expected transfers.
// Revision : 1.0  initial release
// ============================================================================
module tb_iob_sched;

    logic CLK = 1'b0;
    logic nRES;
    logic PWReq, PWL, PWU, NPReq, NPRW, NPL, NPU, BERRin, IOACT, IODONE;
    logic PWReady, PWEmpty, NPDone, NPErr, PWErr, ALE1, ALE0, IOREQ, IORW, IOL, IOU;

    int         nAssert = 0;
    int         nFail   = 0;
    logic [2:0] expQ[$];

    always #5 CLK = ~CLK;

    iob_sched dut (
        .CLK(CLK), .nRES(nRES),
        .PWReq(PWReq), .PWL(PWL), .PWU(PWU), .PWReady(PWReady), .PWEmpty(PWEmpty),
        .NPReq(NPReq), .NPRW(NPRW), .NPL(NPL), .NPU(NPU),
        .NPDone(NPDone), .NPErr(NPErr), .PWErr(PWErr), .BERRin(BERRin),
        .ALE1(ALE1), .ALE0(ALE0),
        .IOREQ(IOREQ), .IORW(IORW), .IOL(IOL), .IOU(IOU),
        .IOACT(IOACT), .IODONE(IODONE)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // IOB master for the transfer whose IOREQ is visible now. Returns on the
    // first cycle in which both synchronised status lines are low again.
    task automatic serve(input bit isNp, input int hold, input logic expReady, input string tag);
        logic [2:0] exp;
        int         d;
        int         w;
        exp = expQ.pop_front();
        chk1({tag, " ioreq"}, IOREQ, 1'b1);
        chk3({tag, " attr"}, {IORW, IOL, IOU}, exp);
        d = $urandom_range(0, 3);
        repeat (d) begin
            tick();
            chk1({tag, " ioreq held"}, IOREQ, 1'b1);
        end
        IOACT = 1'b1;
        tick(); tick(); tick();
        chk1({tag, " ioreq drop"}, IOREQ, 1'b0);
        w = $urandom_range(0, 2);
        repeat (w) tick();
        IODONE = 1'b1;
        IOACT  = 1'b0;
        for (int c = 1; c <= hold + 2; c++) begin
            tick();
            if (c == hold) IODONE = 1'b0;
            chk1({tag, " npdone"}, NPDone, (c == 3) ? isNp : 1'b0);
            chk1({tag, " no early load"}, ALE0, 1'b0);
            chk1({tag, " pwready"}, PWReady, expReady);
            if (c == 3) begin
                chk1({tag, " nperr"}, NPErr, 1'b0);
                chk3({tag, " attr hold"}, {IORW, IOL, IOU}, exp);
                if (isNp) NPReq = 1'b0;
            end
        end
    endtask

    task automatic npTxn(input logic rw, input logic l, input logic u, input int hold, input string tag);
        NPReq = 1'b1; NPRW = rw; NPL = l; NPU = u;
        expQ.push_back({rw, l, u});
        tick();
        chk1({tag, " ale1"}, ALE1, 1'b1);
        chk1({tag, " ale0"}, ALE0, 1'b1);
        chk1({tag, " ioreq early"}, IOREQ, 1'b0);
        tick();
        chk1({tag, " pwempty"}, PWEmpty, 1'b1);
        serve(1'b1, hold, 1'b1, tag);
        tick();
        chk1({tag, " no reissue"}, ALE0, 1'b0);
    endtask

    task automatic pwTxn(input logic l, input logic u, input int hold, input string tag);
        PWReq = 1'b1; PWL = l; PWU = u;
        expQ.push_back({1'b0, l, u});
        tick();
        PWReq = 1'b0;
        chk1({tag, " ale1"}, ALE1, 1'b1);
        chk1({tag, " pwready low"}, PWReady, 1'b0);
        chk1({tag, " pwempty low"}, PWEmpty, 1'b0);
        tick();
        chk1({tag, " ale0"}, ALE0, 1'b1);
        tick();
        chk1({tag, " pwready back"}, PWReady, 1'b1);
        serve(1'b0, hold, 1'b1, tag);
        chk1({tag, " pwempty end"}, PWEmpty, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic rw, l, u;
        nRES = 1'b0; PWReq = 1'b0; PWL = 1'b0; PWU = 1'b0;
        NPReq = 1'b0; NPRW = 1'b0; NPL = 1'b0; NPU = 1'b0;
        BERRin = 1'b0; IOACT = 1'b0; IODONE = 1'b0;
        repeat (3) tick();
        chk1("rst pwready", PWReady, 1'b1);
        chk1("rst pwempty", PWEmpty, 1'b1);
        chk1("rst ioreq", IOREQ, 1'b0);
        chk1("rst ale0", ALE0, 1'b0);
        chk1("rst ale1", ALE1, 1'b0);
        chk1("rst npdone", NPDone, 1'b0);
        chk1("rst pwerr", PWErr, 1'b0);
        nRES = 1'b1;
        repeat (2) tick();

        // Directed NP read, then random non-posted traffic.
        npTxn(1'b1, 1'b1, 1'b0, 2, "np read");
        for (int i = 0; i < 4; i++) begin
            rw = 1'($urandom()); l = 1'($urandom()); u = 1'($urandom());
            npTxn(rw, l, u, $urandom_range(2, 5), "np rand");
        end

        // Two posted writes: second staged while the first is in flight.
        PWReq = 1'b1; PWL = 1'b1; PWU = 1'b0;
        expQ.push_back(3'b010);
        tick();
        PWReq = 1'b0;
        chk1("pw2 ale1 a", ALE1, 1'b1);
        chk1("pw2 ready a", PWReady, 1'b0);
        tick();
        chk1("pw2 ale0 a", ALE0, 1'b1);
        chk1("pw2 ale1 pulse", ALE1, 1'b0);
        tick();
        chk1("pw2 ready back", PWReady, 1'b1);
        PWReq = 1'b1; PWL = 1'b0; PWU = 1'b1;
        expQ.push_back(3'b001);
        tick();
        PWReq = 1'b0;
        chk1("pw2 ale1 b", ALE1, 1'b1);
        chk1("pw2 ready b", PWReady, 1'b0);
        serve(1'b0, $urandom_range(2, 5), 1'b0, "pw2 first");
        tick();
        chk1("pw2 ale0 b", ALE0, 1'b1);
        chk1("pw2 ready at load", PWReady, 1'b0);
        tick();
        chk1("pw2 ready after load", PWReady, 1'b1);
        serve(1'b0, $urandom_range(2, 5), 1'b1, "pw2 second");
        chk1("pw2 empty", PWEmpty, 1'b1);

        // Ordering plus stale IODONE: PW and NP in the same cycle, PW wins.
        rw = 1'($urandom()); l = 1'($urandom()); u = 1'($urandom());
        PWReq = 1'b1; PWL = ~l; PWU = u;
        NPReq = 1'b1; NPRW = rw; NPL = l; NPU = u;
        expQ.push_back({1'b0, ~l, u});
        expQ.push_back({rw, l, u});
        tick();
        PWReq = 1'b0;
        chk1("ord ale1", ALE1, 1'b1);
        chk1("ord np held off", ALE0, 1'b0);
        tick();
        chk1("ord pw load", ALE0, 1'b1);
        chk1("ord ale1 pulse", ALE1, 1'b0);
        tick();
        serve(1'b0, 7, 1'b1, "ord pw");
        tick();
        chk1("ord np ale0", ALE0, 1'b1);
        chk1("ord np ale1", ALE1, 1'b1);
        chk1("ord pwempty", PWEmpty, 1'b1);
        tick();
        serve(1'b1, $urandom_range(2, 5), 1'b1, "ord np");

        // Random posted writes.
        for (int i = 0; i < 4; i++) begin
            l = 1'($urandom()); u = 1'($urandom());
            pwTxn(l, u, $urandom_range(2, 5), "pw rand");
        end

        // Reset in REQ with a second write staged: everything discarded.
        PWReq = 1'b1; PWL = 1'b1; PWU = 1'b1;
        tick(); PWReq = 1'b0;
        tick(); tick();
        chk1("mid ioreq", IOREQ, 1'b1);
        PWReq = 1'b1;
        tick(); PWReq = 1'b0;
        chk1("mid staged", PWReady, 1'b0);
        nRES = 1'b0;
        #1;
        chk1("mid rst ioreq", IOREQ, 1'b0);
        chk1("mid rst ale0", ALE0, 1'b0);
        chk1("mid rst ale1", ALE1, 1'b0);
        chk1("mid rst pwready", PWReady, 1'b1);
        chk1("mid rst pwempty", PWEmpty, 1'b1);
        tick();
        nRES = 1'b1;
        expQ.delete();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("post rst no load", ALE0, 1'b0);
        end
        npTxn(1'b0, 1'b1, 1'b1, 3, "post rst np");

`ifdef IOB_SCHED_BERR_EN
        // Bus error ends an NP access in ACT.
        NPReq = 1'b1; NPRW = 1'b1; NPL = 1'b0; NPU = 1'b1;
        tick(); tick();
        chk1("berr np ioreq", IOREQ, 1'b1);
        IOACT = 1'b1;
        tick(); tick(); tick();
        chk1("berr np in act", IOREQ, 1'b0);
        BERRin = 1'b1; IOACT = 1'b0;
        tick();
        BERRin = 1'b0; NPReq = 1'b0;
        chk1("berr npdone", NPDone, 1'b1);
        chk1("berr nperr", NPErr, 1'b1);
        tick();
        chk1("berr npdone pulse", NPDone, 1'b0);
        chk1("berr nperr pulse", NPErr, 1'b0);
        chk1("berr np pwerr", PWErr, 1'b0);
        repeat (3) tick();

        // Bus error on a posted write is sticky until reset.
        PWReq = 1'b1; PWL = 1'b1; PWU = 1'b0;
        tick(); PWReq = 1'b0;
        tick(); tick();
        chk1("berr pw ioreq", IOREQ, 1'b1);
        IOACT = 1'b1;
        tick(); tick(); tick();
        BERRin = 1'b1; IOACT = 1'b0;
        tick();
        BERRin = 1'b0;
        chk1("berr pwerr set", PWErr, 1'b1);
        chk1("berr pw no npdone", NPDone, 1'b0);
        repeat (3) tick();
        npTxn(1'b1, 1'b1, 1'b1, 2, "berr after");
        chk1("berr pwerr sticky", PWErr, 1'b1);
        nRES = 1'b0;
        #1;
        chk1("berr pwerr rst", PWErr, 1'b0);
        tick();
        nRES = 1'b1;
`else
        // Without the option, BERRin has no effect.
        BERRin = 1'b1;
        npTxn(1'b1, 1'b0, 1'b1, 2, "berr ignored");
        BERRin = 1'b0;
        chk1("berr ignored pwerr", PWErr, 1'b0);
`endif
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
`default_nettype wire
